// File: rtl/cpu86_exec_io.sv
// cpu86_exec_io: sequences IN/OUT micro-ops onto the I/O request stream and returns read data to writeback.
// Defining CPU86_IO_TIMEOUT_EN builds a WAIT_RES watchdog that returns floating-bus data after TIMEOUT_CYCLES.
module cpu86_exec_io #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_axis_op_tvalid,
    output logic        s_axis_op_tready,
    input  logic [33:0] s_axis_op_tdata,
    output logic        m_axis_io_req_tvalid,
    input  logic        m_axis_io_req_tready,
    output logic [39:0] m_axis_io_req_tdata,
    input  logic        s_axis_io_res_tvalid,
    input  logic [15:0] s_axis_io_res_tdata,
    output logic        m_axis_op_res_tvalid,
    input  logic        m_axis_op_res_tready,
    output logic [15:0] m_axis_op_res_tdata,
    output logic        busy,
    output logic        err_unexp_res,
    output logic        io_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, OUTPUT} state_t;
    state_t state, state_n;
    logic word_q;
    logic err_n, tout_n;
    assign s_axis_op_tready = state == IDLE;
`ifdef CPU86_IO_TIMEOUT_EN
    logic [15:0] cnt;
    // A response on the final watchdog cycle takes priority over the timeout
    assign tout_n = state == WAIT_RES && !s_axis_io_res_tvalid && cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!resetn || state != WAIT_RES)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign tout_n = 1'b0;
`endif
    always_comb begin
        state_n = state;
        err_n = s_axis_io_res_tvalid && state != WAIT_RES;
        case (state)
            IDLE:     if (s_axis_op_tvalid) state_n = ISSUE;
            ISSUE:    if (m_axis_io_req_tready) state_n = m_axis_io_req_tdata[32] ? IDLE : WAIT_RES;
            WAIT_RES: if (s_axis_io_res_tvalid || tout_n) state_n = OUTPUT;
            OUTPUT:   if (m_axis_op_res_tready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            word_q <= 1'b0;
            m_axis_io_req_tvalid <= 1'b0;
            m_axis_io_req_tdata <= '0;
            m_axis_op_res_tvalid <= 1'b0;
            m_axis_op_res_tdata <= '0;
            busy <= 1'b0;
            err_unexp_res <= 1'b0;
            io_timeout <= 1'b0;
        end else begin
            state <= state_n;
            m_axis_io_req_tvalid <= state_n == ISSUE;
            m_axis_op_res_tvalid <= state_n == OUTPUT;
            busy <= state_n != IDLE;
            err_unexp_res <= err_n;
            io_timeout <= tout_n;
            if (state == IDLE && s_axis_op_tvalid) begin
                word_q <= s_axis_op_tdata[33];
                m_axis_io_req_tdata <= {7'b0, s_axis_op_tdata[32], s_axis_op_tdata[31:16],
                                        s_axis_op_tdata[33] ? s_axis_op_tdata[15:8] : 8'h00, s_axis_op_tdata[7:0]};
            end
            // Timeout substitutes all-ones, i.e. the undriven 8086 bus
            if (state == WAIT_RES && (s_axis_io_res_tvalid || tout_n))
                m_axis_op_res_tdata <= {word_q ? (s_axis_io_res_tvalid ? s_axis_io_res_tdata[15:8] : 8'hFF) : 8'h00,
                                        s_axis_io_res_tvalid ? s_axis_io_res_tdata[7:0] : 8'hFF};
        end
    end
endmodule
